xbar_aw_w_sequencer: RTL and testbench

Slave-side write-path sequencer for the crossbar, one instance per slave port. It round-robin arbitrates AW requests from all masters targeting this slave and tags each AWID with the source master index. It tracks up to OUTSTANDING accepted write bursts in an order queue and routes W beats from the master at the queue head, so several AWs can be in flight before their data. W beat counts are checked against AWLEN, and WLAST toward the slave is generated from the count.

---
 rtl/xbar_aw_w_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_xbar_aw_w_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_aw_w_sequencer.sv
// Slave-side write-path sequencer: round-robin AW arbitration across masters, an order
// queue of accepted bursts, and W routing from the queue head with count-generated WLAST.
module xbar_aw_w_sequencer #(
  parameter int MASTERS           = 2,
  parameter int SLAVES            = 2,
  parameter int I_AM_SLAVE_NUMBER = 0,
  parameter int ID_WIDTH          = 4,
  parameter int ADDR_WIDTH        = 32,
  parameter int LEN_WIDTH         = 4,
  parameter int DATA_WIDTH        = 32,
  parameter int STRB_WIDTH        = 4,
  parameter int OUTSTANDING       = 4,
  localparam int MW        = (MASTERS > 1) ? $clog2(MASTERS) : 1,
  localparam int SW        = (SLAVES > 1) ? $clog2(SLAVES) : 1,
  localparam int IDS_WIDTH = ID_WIDTH + MW,
  localparam int QW        = $clog2(OUTSTANDING)
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [MASTERS-1:0]               m_aw_valid,
  input  logic [MASTERS*SW-1:0]            m_aw_dest,
  input  logic [MASTERS*ID_WIDTH-1:0]      m_awid,
  input  logic [MASTERS*ADDR_WIDTH-1:0]    m_awaddr,
  input  logic [MASTERS*LEN_WIDTH-1:0]     m_awlen,
  output logic [MASTERS-1:0]               m_aw_ready,
  input  logic [MASTERS-1:0]               m_w_valid,
  input  logic [MASTERS*DATA_WIDTH-1:0]    m_wdata,
  input  logic [MASTERS*STRB_WIDTH-1:0]    m_wstrb,
  input  logic [MASTERS-1:0]               m_wlast,
  output logic [MASTERS-1:0]               m_w_ready,
  output logic [IDS_WIDTH-1:0]             AWID_S,
  output logic [ADDR_WIDTH-1:0]            AWADDR_S,
  output logic [LEN_WIDTH-1:0]             AWLEN_S,
  output logic                             AWVALID_S,
  input  logic                             AWREADY_S,
  output logic [DATA_WIDTH-1:0]            WDATA_S,
  output logic [STRB_WIDTH-1:0]            WSTRB_S,
  output logic                             WLAST_S,
  output logic                             WVALID_S,
  input  logic                             WREADY_S,
  output logic                             w_len_err,
  output logic [QW:0]                      outstanding
);

  logic [MASTERS-1:0]    eligible;
  logic                  hi_found, lo_found, grant_valid;
  logic [MW-1:0]         hi_idx, lo_idx, grant_idx;
  logic [MW-1:0]         rr_ptr;
  logic                  aw_valid_q, aw_free, aw_accept;
  logic [MW-1:0]         aw_master_q;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [LEN_WIDTH-1:0]  aw_len_q;

  logic [MW-1:0]         q_master [OUTSTANDING];
  logic [LEN_WIDTH-1:0]  q_len    [OUTSTANDING];
  logic [QW-1:0]         wr_ptr, rd_ptr;
  logic [QW:0]           q_count;
  logic                  q_full, q_nonempty, push, pop;
  logic [MW-1:0]         head_master;
  logic [LEN_WIDTH-1:0]  head_len;
  logic                  head_wlast;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  w_route, w_hs;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < MASTERS; i++) begin
      eligible[i] = m_aw_valid[i] && (m_aw_dest[i*SW +: SW] == SW'(I_AM_SLAVE_NUMBER));
    end
  end

  // Lowest eligible index at or above rr_ptr wins; otherwise wrap to the lowest below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = MW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = MW'(i);
        end
      end
    end
    grant_valid = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign aw_free   = !aw_valid_q || AWREADY_S;
  assign q_full    = (q_count == (QW+1)'(OUTSTANDING));
  assign aw_accept = !ARESET && grant_valid && aw_free && !q_full;
  assign push      = aw_accept;

  always_comb begin
    m_aw_ready = '0;
    if (aw_accept) begin
      m_aw_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_valid_q <= 1'b0;
      rr_ptr     <= '0;
    end else if (aw_accept) begin
      aw_valid_q <= 1'b1;
      rr_ptr     <= (grant_idx == MW'(MASTERS - 1)) ? '0 : grant_idx + 1'b1;
    end else if (AWREADY_S) begin
      aw_valid_q <= 1'b0;
    end
  end

  // Payload and queue storage carry no reset; only the valid flag and pointers matter.
  always_ff @(posedge ACLK) begin
    if (aw_accept) begin
      aw_master_q <= grant_idx;
      aw_id_q     <= m_awid[grant_idx*ID_WIDTH +: ID_WIDTH];
      aw_addr_q   <= m_awaddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      aw_len_q    <= m_awlen[grant_idx*LEN_WIDTH +: LEN_WIDTH];
    end
    if (push) begin
      q_master[wr_ptr] <= grant_idx;
      q_len[wr_ptr]    <= m_awlen[grant_idx*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  assign AWVALID_S = aw_valid_q;
  assign AWID_S    = {aw_master_q, aw_id_q};
  assign AWADDR_S  = aw_addr_q;
  assign AWLEN_S   = aw_len_q;

  assign head_master = q_master[rd_ptr];
  assign head_len    = q_len[rd_ptr];
  assign q_nonempty  = (q_count != '0);
  assign w_route     = q_nonempty && !ARESET;

  always_comb begin
    m_w_ready  = '0;
    WVALID_S   = 1'b0;
    WLAST_S    = 1'b0;
    WDATA_S    = m_wdata[head_master*DATA_WIDTH +: DATA_WIDTH];
    WSTRB_S    = m_wstrb[head_master*STRB_WIDTH +: STRB_WIDTH];
    head_wlast = m_wlast[head_master];
    if (w_route) begin
      WVALID_S               = m_w_valid[head_master];
      WLAST_S                = (beat_cnt == head_len);
      m_w_ready[head_master] = WREADY_S;
    end
  end

  assign w_hs = WVALID_S && WREADY_S;
  assign pop  = w_hs && WLAST_S;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_count   <= '0;
      beat_cnt  <= '0;
      w_len_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
      if (pop) begin
        beat_cnt <= '0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      w_len_err <= w_hs && (head_wlast != WLAST_S);
    end
  end

  assign outstanding = q_count;

endmodule

// File: tb/tb_xbar_aw_w_sequencer.sv
// Bench for xbar_aw_w_sequencer: a vector table, directed corner sequences, and random
// traffic checked every cycle against a queue-based reference model.
module tb_xbar_aw_w_sequencer;

  localparam int M   = 2;
  localparam int SW  = 1;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int LW  = 4;
  localparam int DW  = 32;
  localparam int STW = 4;
  localparam int OUT = 4;

  logic            ACLK;
  logic            ARESET;
  logic [M-1:0]    m_aw_valid;
  logic [M*SW-1:0] m_aw_dest;
  logic [M*IDW-1:0] m_awid;
  logic [M*AW-1:0] m_awaddr;
  logic [M*LW-1:0] m_awlen;
  logic [M-1:0]    m_aw_ready;
  logic [M-1:0]    m_w_valid;
  logic [M*DW-1:0] m_wdata;
  logic [M*STW-1:0] m_wstrb;
  logic [M-1:0]    m_wlast;
  logic [M-1:0]    m_w_ready;
  logic [IDW:0]    AWID_S;
  logic [AW-1:0]   AWADDR_S;
  logic [LW-1:0]   AWLEN_S;
  logic            AWVALID_S;
  logic            AWREADY_S;
  logic [DW-1:0]   WDATA_S;
  logic [STW-1:0]  WSTRB_S;
  logic            WLAST_S;
  logic            WVALID_S;
  logic            WREADY_S;
  logic            w_len_err;
  logic [2:0]      outstanding;

  int n_checks = 0;
  int n_errors = 0;

  xbar_aw_w_sequencer dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_aw_valid(m_aw_valid), .m_aw_dest(m_aw_dest), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_aw_ready(m_aw_ready),
    .m_w_valid(m_w_valid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_w_ready(m_w_ready),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
    .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
    .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
    .w_len_err(w_len_err), .outstanding(outstanding)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge for sampling.
  task automatic apply_stimulus(input logic rst, input logic [1:0] awv, input logic [1:0] dest,
                                input logic [3:0] len0, input logic [3:0] len1,
                                input logic [1:0] wv, input logic [1:0] wl,
                                input logic awr, input logic wr, input bit rnd);
    @(posedge ACLK);
    #1;
    ARESET     = rst;
    m_aw_valid = awv;
    m_aw_dest  = dest;
    m_awlen    = {len1, len0};
    m_w_valid  = wv;
    m_wlast    = wl;
    AWREADY_S  = awr;
    WREADY_S   = wr;
    if (rnd) begin
      m_awid   = 8'($urandom);
      m_awaddr = {$urandom(), $urandom()};
      m_wdata  = {$urandom(), $urandom()};
      m_wstrb  = 8'($urandom);
    end
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
  endtask

  // Reference model: bursts as a queue of {master, len}, one AW holding slot, a beat count.
  typedef struct { int m; int len; } burst_t;
  burst_t     mq[$];
  bit         mdl_awv = 1'b0;
  logic [4:0] mdl_awid;
  logic [31:0] mdl_awaddr;
  logic [3:0] mdl_awlen;
  int         mdl_rr = 0;
  int         mdl_beat = 0;
  bit         mdl_err = 1'b0;

  task automatic model_cycle();
    int     grant;
    bit     found, accept, hs, last, wvalid, busy;
    int     h, hlen;
    logic [1:0] exp_ready, exp_wready;
    found = 1'b0;
    grant = 0;
    for (int k = 0; k < M; k++) begin
      automatic int c = (mdl_rr + k) % M;
      if (!found && m_aw_valid[c] && m_aw_dest[c*SW +: SW] == 1'b0) begin
        found = 1'b1;
        grant = c;
      end
    end
    accept    = !ARESET && found && (!mdl_awv || AWREADY_S) && (mq.size() < OUT);
    exp_ready = accept ? (2'b01 << grant) : 2'b00;
    busy      = (mq.size() > 0) && !ARESET;
    h         = (mq.size() > 0) ? mq[0].m : 0;
    hlen      = (mq.size() > 0) ? mq[0].len : 0;
    wvalid    = busy && m_w_valid[h];
    last      = busy && (mdl_beat == hlen);
    exp_wready = (busy && WREADY_S) ? (2'b01 << h) : 2'b00;

    check_output("mdl_aw_ready", m_aw_ready, exp_ready);
    check_output("mdl_awvalid", AWVALID_S, mdl_awv);
    if (mdl_awv) begin
      check_output("mdl_awid", AWID_S, mdl_awid);
      check_output("mdl_awaddr", AWADDR_S, mdl_awaddr);
      check_output("mdl_awlen", AWLEN_S, mdl_awlen);
    end
    check_output("mdl_wvalid", WVALID_S, wvalid);
    check_output("mdl_wlast", WLAST_S, last);
    check_output("mdl_w_ready", m_w_ready, exp_wready);
    if (wvalid) begin
      check_output("mdl_wdata", WDATA_S, m_wdata[h*DW +: DW]);
      check_output("mdl_wstrb", WSTRB_S, m_wstrb[h*STW +: STW]);
    end
    check_output("mdl_w_len_err", w_len_err, mdl_err);
    check_output("mdl_outstanding", outstanding, mq.size());

    if (ARESET) begin
      mq.delete();
      mdl_awv  = 1'b0;
      mdl_rr   = 0;
      mdl_beat = 0;
      mdl_err  = 1'b0;
    end else begin
      hs      = wvalid && WREADY_S;
      mdl_err = hs && (m_wlast[h] != last);
      if (hs) begin
        if (last) begin
          void'(mq.pop_front());
          mdl_beat = 0;
        end else begin
          mdl_beat++;
        end
      end
      if (accept) begin
        mdl_awv    = 1'b1;
        mdl_awid   = {1'(grant), m_awid[grant*IDW +: IDW]};
        mdl_awaddr = m_awaddr[grant*AW +: AW];
        mdl_awlen  = m_awlen[grant*LW +: LW];
        mq.push_back('{m: grant, len: int'(m_awlen[grant*LW +: LW])});
        mdl_rr     = (grant + 1) % M;
      end else if (AWREADY_S) begin
        mdl_awv = 1'b0;
      end
    end
  endtask

  initial begin
    @(posedge ACLK);
    forever begin
      @(negedge ACLK);
      model_cycle();
    end
  end

  typedef struct {
    logic [1:0] awv;
    logic [1:0] dest;
    logic       awr;
    logic [1:0] exp_ready;
    logic       exp_awvalid;
    logic       exp_awid_msb;
    logic [2:0] exp_out;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 3'd1};
    vecs[2]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 3'd1};
    vecs[3]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 3'd1};
    vecs[4]  = '{2'b11, 2'b01, 1'b1, 2'b10, 1'b1, 1'b1, 3'd1};
    vecs[5]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 3'd1};
    vecs[6]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0};
    vecs[7]  = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 3'd1};
    vecs[9]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3'd0};
    vecs[10] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0};

    ARESET     = 1'b1;
    m_aw_valid = '0;
    m_aw_dest  = '0;
    m_awid     = 8'h93;
    m_awaddr   = {32'h2000_0000, 32'h1000_0000};
    m_awlen    = '0;
    m_w_valid  = '0;
    m_wdata    = {32'hB1B1_0001, 32'hA0A0_0000};
    m_wstrb    = 8'hF5;
    m_wlast    = '0;
    AWREADY_S  = 1'b1;
    WREADY_S   = 1'b1;

    do_reset();
    check_output("rst_awvalid", AWVALID_S, 1'b0);
    check_output("rst_aw_ready", m_aw_ready, 2'b00);
    check_output("rst_w_ready", m_w_ready, 2'b00);
    check_output("rst_wvalid", WVALID_S, 1'b0);
    check_output("rst_wlast", WLAST_S, 1'b0);
    check_output("rst_w_len_err", w_len_err, 1'b0);
    check_output("rst_outstanding", outstanding, 3'd0);

    // Arbitration table: both W streams always ready with single-beat bursts.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(1'b0, vecs[i].awv, vecs[i].dest, 4'd0, 4'd0, 2'b11, 2'b11,
                     vecs[i].awr, 1'b1, 1'b0);
      check_output($sformatf("tbl%0d_aw_ready", i), m_aw_ready, vecs[i].exp_ready);
      check_output($sformatf("tbl%0d_awvalid", i), AWVALID_S, vecs[i].exp_awvalid);
      if (vecs[i].exp_awvalid)
        check_output($sformatf("tbl%0d_awid_msb", i), AWID_S[IDW], vecs[i].exp_awid_msb);
      check_output($sformatf("tbl%0d_outstanding", i), outstanding, vecs[i].exp_out);
    end

    // Full queue: fifth AW waits, and is not admitted on the pop cycle.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      apply_stimulus(1'b0, 2'b10, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      check_output($sformatf("fill%0d_aw_ready", c), m_aw_ready, 2'b10);
      check_output($sformatf("fill%0d_outstanding", c), outstanding, 3'(c));
    end
    apply_stimulus(1'b0, 2'b10, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    check_output("full_aw_ready", m_aw_ready, 2'b00);
    check_output("full_outstanding", outstanding, 3'd4);
    apply_stimulus(1'b0, 2'b10, 2'b00, 4'd0, 4'd0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0);
    check_output("popcyc_aw_ready", m_aw_ready, 2'b00);
    check_output("popcyc_wvalid", WVALID_S, 1'b1);
    check_output("popcyc_outstanding", outstanding, 3'd4);
    apply_stimulus(1'b0, 2'b10, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    check_output("afterpop_aw_ready", m_aw_ready, 2'b10);
    check_output("afterpop_outstanding", outstanding, 3'd3);

    // Back-to-back bursts: m0 four beats then m1 two beats with no gap.
    do_reset();
    apply_stimulus(1'b0, 2'b01, 2'b00, 4'd3, 4'd1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0);
    check_output("b2b_first_aw_ready", m_aw_ready, 2'b01);
    check_output("b2b_first_wvalid", WVALID_S, 1'b0);
    check_output("b2b_first_w_ready", m_w_ready, 2'b00);
    for (int k = 0; k < 6; k++) begin
      automatic int   head = (k < 4) ? 0 : 1;
      automatic logic last = (k == 3) || (k == 5);
      automatic logic [1:0] wl = last ? ((head == 1) ? 2'b10 : 2'b01) : 2'b00;
      apply_stimulus(1'b0, (k == 0) ? 2'b10 : 2'b00, 2'b00, 4'd3, 4'd1, 2'b11, wl,
                     1'b1, 1'b1, 1'b0);
      if (k == 0) check_output("b2b_second_aw_ready", m_aw_ready, 2'b10);
      check_output($sformatf("b2b%0d_wvalid", k), WVALID_S, 1'b1);
      check_output($sformatf("b2b%0d_wlast", k), WLAST_S, last);
      check_output($sformatf("b2b%0d_w_ready", k), m_w_ready, (head == 1) ? 2'b10 : 2'b01);
      check_output($sformatf("b2b%0d_wdata", k), WDATA_S,
                   (head == 1) ? 32'hB1B1_0001 : 32'hA0A0_0000);
    end
    apply_stimulus(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    check_output("b2b_end_outstanding", outstanding, 3'd0);
    check_output("b2b_end_err", w_len_err, 1'b0);

    // Early upstream WLAST on beat 2 of 3.
    do_reset();
    apply_stimulus(1'b0, 2'b01, 2'b00, 4'd2, 4'd0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 2'b00, 2'b00, 4'd2, 4'd0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    check_output("err_b1_wlast", WLAST_S, 1'b0);
    check_output("err_b1_err", w_len_err, 1'b0);
    apply_stimulus(1'b0, 2'b00, 2'b00, 4'd2, 4'd0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    check_output("err_b2_wlast", WLAST_S, 1'b0);
    check_output("err_b2_err", w_len_err, 1'b0);
    apply_stimulus(1'b0, 2'b00, 2'b00, 4'd2, 4'd0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    check_output("err_b3_wlast", WLAST_S, 1'b1);
    check_output("err_b3_err", w_len_err, 1'b1);
    check_output("err_b3_outstanding", outstanding, 3'd1);
    apply_stimulus(1'b0, 2'b00, 2'b00, 4'd2, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    check_output("err_after_err", w_len_err, 1'b0);
    check_output("err_after_outstanding", outstanding, 3'd0);

    // AW stall with W flowing, then reset in the middle of the burst.
    do_reset();
    apply_stimulus(1'b0, 2'b01, 2'b00, 4'd3, 4'd0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    check_output("mid_aw_ready", m_aw_ready, 2'b01);
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b0, 2'b00, 2'b00, 4'd3, 4'd0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
      check_output($sformatf("stall%0d_awvalid", k), AWVALID_S, 1'b1);
      check_output($sformatf("stall%0d_awid", k), AWID_S, 5'h03);
      check_output($sformatf("stall%0d_awaddr", k), AWADDR_S, 32'h1000_0000);
      check_output($sformatf("stall%0d_awlen", k), AWLEN_S, 4'd3);
      check_output($sformatf("stall%0d_wvalid", k), WVALID_S, 1'b1);
    end
    apply_stimulus(1'b1, 2'b00, 2'b00, 4'd3, 4'd0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 2'b11, 2'b00, 4'd3, 4'd3, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    check_output("postrst_outstanding", outstanding, 3'd0);
    check_output("postrst_wvalid", WVALID_S, 1'b0);
    check_output("postrst_awvalid", AWVALID_S, 1'b0);
    check_output("postrst_rr_grant", m_aw_ready, 2'b01);

    // Random traffic, checked by the model process every cycle.
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(($urandom_range(0, 299) == 0), 2'($urandom), 2'($urandom),
                     4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     2'($urandom), 2'($urandom),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b1);
    end

    apply_stimulus(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
